// File: rtl/instr_wb_pkg.sv
// Shared constants and the default-width response entry for the instrumented
// Wishbone pipelined slave.
package instr_wb_pkg;

  localparam int MIN_LATENCY   = 1;
  localparam int DEF_LAT_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;

  // Modules with non-default widths declare a local struct of the same shape.
  typedef struct packed {
    logic [DEF_LAT_WIDTH-1:0]  rem;
    logic                      is_err;
    logic [DEF_DATA_WIDTH-1:0] data;
  } resp_entry_t;

endpackage

// File: rtl/instr_wb_resp_fifo.sv
// In-order response queue: every live entry counts its remaining latency down,
// and only the head may answer once its countdown reaches zero.
module instr_wb_resp_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 4,
  parameter int DEPTH      = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [LAT_WIDTH-1:0]  push_rem_i,
  input  logic                  push_err_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  head_ready_o,
  output logic                  head_err_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [CW-1:0]         count_o
);

  typedef struct packed {
    logic [LAT_WIDTH-1:0]  rem;
    logic                  is_err;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    logic [PW-1:0] age;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // An entry is live when its distance from the head is below the occupancy.
    for (int i = 0; i < DEPTH; i++) begin
      age = PW'(i) - rd_ptr_q;
      if ((CW'(age) < count_q) && (mem_q[i].rem != '0))
        mem_d[i].rem = mem_q[i].rem - 1'b1;
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = '{rem: push_rem_i, is_err: push_err_i, data: push_data_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)
      count_d = count_q + 1'b1;
    else if (pop_i && !push_i)
      count_d = count_q - 1'b1;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head_ready_o = (count_q != '0) && (mem_q[rd_ptr_q].rem == '0);
  assign head_err_o   = mem_q[rd_ptr_q].is_err;
  assign head_data_o  = mem_q[rd_ptr_q].data;
  assign count_o      = count_q;

endmodule

// File: rtl/instr_wb_slave_pipelined.sv
// Instrumented Wishbone B4 pipelined slave: queues up to DEPTH requests and
// answers them in order after a per-request latency, with injectable data/err.
module instr_wb_slave_pipelined
  import instr_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LAT_WIDTH  = 4,
  localparam int SW = DATA_WIDTH / 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_we_i,
  input  logic [SW-1:0]         wb_sel_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic                  wb_cyc_i,
  output logic                  wb_stall_o,
  input  logic                  stall_request_i,
  input  logic [DATA_WIDTH-1:0] injected_data_i,
  input  logic                  err_request_i,
  input  logic [LAT_WIDTH-1:0]  ack_latency_i,
  output logic [ADDR_WIDTH-1:0] last_adr_o,
  output logic [DATA_WIDTH-1:0] last_dat_o,
  output logic [SW-1:0]         last_sel_o,
  output logic                  last_we_o,
  output logic [CW-1:0]         outstanding_o,
  output logic [31:0]           req_count_o
);

  logic                  accept;
  logic                  resp_vld;
  logic                  head_ready, head_err;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CW-1:0]         count;
  logic [LAT_WIDTH-1:0]  push_rem;
  logic [DATA_WIDTH-1:0] push_data;

  logic [ADDR_WIDTH-1:0] last_adr_q, last_adr_d;
  logic [DATA_WIDTH-1:0] last_dat_q, last_dat_d;
  logic [SW-1:0]         last_sel_q, last_sel_d;
  logic                  last_we_q,  last_we_d;
  logic [31:0]           req_count_q, req_count_d;

  // Full stalls even when the head pops this cycle.
  assign wb_stall_o = stall_request_i | (count == CW'(DEPTH));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign resp_vld   = head_ready & wb_cyc_i;

  // Latency 0 behaves as the minimum; rem counts the cycles beyond it.
  assign push_rem  = (ack_latency_i <= LAT_WIDTH'(MIN_LATENCY)) ? '0
                   : ack_latency_i - LAT_WIDTH'(MIN_LATENCY);
  assign push_data = wb_we_i ? '0 : injected_data_i;

  instr_wb_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAT_WIDTH  (LAT_WIDTH),
    .DEPTH      (DEPTH)
  ) u_resp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (~wb_cyc_i),
    .push_i       (accept),
    .push_rem_i   (push_rem),
    .push_err_i   (err_request_i),
    .push_data_i  (push_data),
    .pop_i        (resp_vld),
    .head_ready_o (head_ready),
    .head_err_o   (head_err),
    .head_data_o  (head_data),
    .count_o      (count)
  );

  always_comb begin
    last_adr_d  = last_adr_q;
    last_dat_d  = last_dat_q;
    last_sel_d  = last_sel_q;
    last_we_d   = last_we_q;
    req_count_d = req_count_q;
    if (accept) begin
      last_adr_d  = wb_adr_i;
      last_dat_d  = wb_dat_i;
      last_sel_d  = wb_sel_i;
      last_we_d   = wb_we_i;
      req_count_d = req_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_adr_q  <= '0;
      last_dat_q  <= '0;
      last_sel_q  <= '0;
      last_we_q   <= 1'b0;
      req_count_q <= '0;
    end else begin
      last_adr_q  <= last_adr_d;
      last_dat_q  <= last_dat_d;
      last_sel_q  <= last_sel_d;
      last_we_q   <= last_we_d;
      req_count_q <= req_count_d;
    end
  end

  assign wb_ack_o      = resp_vld & ~head_err;
  assign wb_err_o      = resp_vld & head_err;
  assign wb_dat_o      = resp_vld ? head_data : '0;
  assign last_adr_o    = last_adr_q;
  assign last_dat_o    = last_dat_q;
  assign last_sel_o    = last_sel_q;
  assign last_we_o     = last_we_q;
  assign outstanding_o = count;
  assign req_count_o   = req_count_q;

endmodule

// File: tb/tb_instr_wb_slave_pipelined.sv
// Directed bench for instr_wb_slave_pipelined: latency, throughput, full stall,
// ordering, error injection, cyc drop and mid-queue reset.
module tb_instr_wb_slave_pipelined;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o, injected_data_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o, wb_stall_o;
  logic [3:0]  wb_sel_i, ack_latency_i, last_sel_o;
  logic        stall_request_i, err_request_i, last_we_o;
  logic [31:0] last_adr_o, last_dat_o, req_count_o;
  logic [2:0]  outstanding_o;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk_i = ~clk_i;

  instr_wb_slave_pipelined dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_cyc_i(wb_cyc_i),
    .wb_stall_o(wb_stall_o), .stall_request_i(stall_request_i),
    .injected_data_i(injected_data_i), .err_request_i(err_request_i),
    .ack_latency_i(ack_latency_i), .last_adr_o(last_adr_o),
    .last_dat_o(last_dat_o), .last_sel_o(last_sel_o), .last_we_o(last_we_o),
    .outstanding_o(outstanding_o), .req_count_o(req_count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step(); step();
    rst_i = 1'b0; wb_cyc_i = 1'b1;
  endtask

  // Steps until ack or err is seen; n returns the number of steps (limit+1 on timeout).
  task automatic wait_resp(input int limit, output int steps);
    steps = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (wb_ack_o || wb_err_o) begin
        steps = i;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ack"}, wb_ack_o, 0);
    chk({tag, "_err"}, wb_err_o, 0);
    chk({tag, "_dat"}, wb_dat_o, 0);
    chk({tag, "_adr"}, last_adr_o, 0);
    chk({tag, "_ldat"}, last_dat_o, 0);
    chk({tag, "_sel"}, last_sel_o, 0);
    chk({tag, "_we"}, last_we_o, 0);
    chk({tag, "_outst"}, outstanding_o, 0);
    chk({tag, "_cnt"}, req_count_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_adr_i = 0; wb_dat_i = 0; wb_we_i = 0; wb_sel_i = 4'hF; wb_stb_i = 0;
    wb_cyc_i = 0; stall_request_i = 0; injected_data_i = 0; err_request_i = 0;
    ack_latency_i = 4'd1; rst_i = 1'b1;

    // Reset state
    do_reset();
    check_idle("rst");
    chk("rst_stall", wb_stall_o, 0);

    // Single read, L=3
    wb_stb_i = 1; wb_adr_i = 32'h100; ack_latency_i = 4'd3; injected_data_i = 32'hDEADBEEF;
    step();
    wb_stb_i = 0;
    chk("l3_ack_k", wb_ack_o, 0);
    chk("l3_outst", outstanding_o, 1);
    chk("l3_cnt", req_count_o, 1);
    chk("l3_ladr", last_adr_o, 32'h100);
    step();
    chk("l3_ack_k1", wb_ack_o, 0);
    step();
    chk("l3_ack_k2", wb_ack_o, 1);
    chk("l3_dat_k2", wb_dat_o, 32'hDEADBEEF);
    step();
    chk("l3_ack_k3", wb_ack_o, 0);
    chk("l3_outst_end", outstanding_o, 0);

    // L=1 back-to-back throughput
    do_reset();
    ack_latency_i = 4'd1;
    for (int i = 1; i <= 6; i++) begin
      chk("b2b_stall", wb_stall_o, 0);
      wb_stb_i = 1; injected_data_i = i;
      step();
      chk("b2b_ack", wb_ack_o, 1);
      chk("b2b_dat", wb_dat_o, i);
    end
    wb_stb_i = 0;
    step();
    chk("b2b_ack_end", wb_ack_o, 0);
    chk("b2b_cnt", req_count_o, 6);

    // L=15 fills the queue and stalls
    do_reset();
    ack_latency_i = 4'd15;
    for (int i = 0; i < 4; i++) begin
      wb_stb_i = 1; injected_data_i = 32'hA0 + i;
      step();
    end
    injected_data_i = 32'hA4;
    chk("full_stall", wb_stall_o, 1);
    chk("full_outst", outstanding_o, 4);
    wait_resp(30, n);
    chk("full_wait", n, 11);
    chk("full_dat0", wb_dat_o, 32'hA0);
    chk("full_stall_pop", wb_stall_o, 1);
    step();
    chk("full_outst3", outstanding_o, 3);
    chk("full_cnt4", req_count_o, 4);
    chk("full_dat1", wb_dat_o, 32'hA1);
    step();
    wb_stb_i = 0;
    chk("full_cnt5", req_count_o, 5);
    chk("full_dat2", wb_dat_o, 32'hA2);
    step();
    chk("full_dat3", wb_dat_o, 32'hA3);
    chk("full_outst2", outstanding_o, 2);
    step();
    chk("full_gap", wb_ack_o, 0);
    chk("full_outst1", outstanding_o, 1);
    wait_resp(30, n);
    chk("full_wait4", n, 12);
    chk("full_dat4", wb_dat_o, 32'hA4);

    // Latency drop 8 -> 1 stays in order
    do_reset();
    wb_stb_i = 1; ack_latency_i = 4'd8; injected_data_i = 32'h11;
    step();
    ack_latency_i = 4'd1; injected_data_i = 32'h22;
    step();
    wb_stb_i = 0;
    chk("ord_blocked", wb_ack_o, 0);
    wait_resp(20, n);
    chk("ord_wait", n, 6);
    chk("ord_dat_a", wb_dat_o, 32'h11);
    step();
    chk("ord_ack_b", wb_ack_o, 1);
    chk("ord_dat_b", wb_dat_o, 32'h22);
    step();
    chk("ord_idle", wb_ack_o, 0);
    chk("ord_outst", outstanding_o, 0);

    // Writes with error on the 2nd
    do_reset();
    ack_latency_i = 4'd2; wb_we_i = 1; wb_sel_i = 4'hF; injected_data_i = 32'hFFFFFFFF;
    wb_stb_i = 1; wb_adr_i = 32'h10; wb_dat_i = 32'h100;
    step();
    chk("wr_ack0", wb_ack_o, 0);
    wb_adr_i = 32'h14; wb_dat_i = 32'h200; err_request_i = 1;
    step();
    chk("wr_ack1", wb_ack_o, 1);
    chk("wr_dat1", wb_dat_o, 0);
    wb_adr_i = 32'h18; wb_dat_i = 32'h300; err_request_i = 0;
    step();
    wb_stb_i = 0; wb_we_i = 0;
    chk("wr_err2", wb_err_o, 1);
    chk("wr_noack2", wb_ack_o, 0);
    step();
    chk("wr_ack3", wb_ack_o, 1);
    chk("wr_noerr3", wb_err_o, 0);
    chk("wr_ladr", last_adr_o, 32'h18);
    chk("wr_lwe", last_we_o, 1);
    chk("wr_lsel", last_sel_o, 4'hF);
    chk("wr_ldat", last_dat_o, 32'h300);
    step();
    chk("wr_outst", outstanding_o, 0);

    // cyc drop while the head is ready: no response in that cycle
    do_reset();
    ack_latency_i = 4'd0; wb_stb_i = 1; wb_adr_i = 32'h40; injected_data_i = 32'h55;
    step();
    wb_stb_i = 0;
    chk("cyc0_ack_pre", wb_ack_o, 1);
    wb_cyc_i = 0;
    #1;
    chk("cyc0_ack", wb_ack_o, 0);
    chk("cyc0_dat", wb_dat_o, 0);
    step();
    chk("cyc0_outst", outstanding_o, 0);

    // cyc drop with 3 pending, then reset mid-queue
    wb_cyc_i = 1; ack_latency_i = 4'd10;
    for (int i = 0; i < 3; i++) begin
      wb_stb_i = 1; wb_adr_i = 32'h80 + 4 * i;
      step();
    end
    wb_stb_i = 0;
    chk("drop_outst3", outstanding_o, 3);
    wb_cyc_i = 0;
    step();
    chk("drop_outst0", outstanding_o, 0);
    chk("drop_ladr", last_adr_o, 32'h88);
    chk("drop_cnt", req_count_o, 4);
    wb_cyc_i = 1;
    wait_resp(15, n);
    chk("drop_noresp", n, 16);
    for (int i = 0; i < 2; i++) begin
      wb_stb_i = 1; wb_adr_i = 32'hC0 + 4 * i;
      step();
    end
    wb_stb_i = 0;
    chk("mid_outst2", outstanding_o, 2);
    rst_i = 1;
    step();
    rst_i = 0;
    check_idle("mid");
    wait_resp(15, n);
    chk("mid_noresp", n, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
